// File: rtl/iic_target_regs.sv
// I2C target with a byte-wide register file and a local fabric access port.
// Open-drain SDA is driven through sda_o/sda_t; SCL is observed only.
module iic_target_regs #(
    parameter logic [6:0]  I2C_ADDR   = 7'h50,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned FILTER_LEN = 3,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_t,
    output logic          busy,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic          loc_wr_en,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic [7:0]    loc_rdata
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    // Line index 0 = SCL, 1 = SDA
    logic [1:0]    meta_q, sync_q, filt_q, filt_p_q;
    logic [CW-1:0] fcnt_q [2];
    logic          fall_d_q;

    state_e        state_q, state_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          first_q, first_d;
    logic          sda_t_q, sda_t_d;
    logic          busy_q, busy_d;
    logic          wr_valid_q, wr_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    loc_rdata_q, loc_rdata_d;
    logic [7:0]    regs_q [NUM_REGS];

    logic          scl_f, sda_f, scl_p, sda_p;
    logic          start_c, stop_c, rise_c, fall_c;
    logic          i2c_we_c;
    logic [7:0]    rx_byte_c;

    assign scl_f = filt_q[0];
    assign sda_f = filt_q[1];
    assign scl_p = filt_p_q[0];
    assign sda_p = filt_p_q[1];

    assign start_c = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_c  = scl_f & scl_p & ~sda_p & sda_f;
    assign rise_c  = scl_f & ~scl_p;
    assign fall_c  = ~scl_f & scl_p;

    assign rx_byte_c = {sh_q[6:0], sda_f};

    assign sda_o     = 1'b0;
    assign sda_t     = sda_t_q;
    assign busy      = busy_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign loc_rdata = loc_rdata_q;

    // Synchronize both lines and require FILTER_LEN equal samples before a change
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q    <= '1;
            sync_q    <= '1;
            filt_q    <= '1;
            filt_p_q  <= '1;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            fall_d_q  <= 1'b0;
        end else begin
            meta_q   <= {sda_i, scl_i};
            sync_q   <= meta_q;
            filt_p_q <= filt_q;
            fall_d_q <= fall_c;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Protocol state register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            loc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            loc_rdata_q <= loc_rdata_d;
        end
    end

    // Next-state logic: bits sampled on SCL rise, SDA updated one cycle after SCL fall
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        sh_d       = sh_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        first_d    = first_q;
        sda_t_d    = sda_t_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        i2c_we_c   = 1'b0;

        if (stop_c) begin
            state_d = ST_IDLE;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else if (start_c) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            sda_t_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_t_d = 1'b1;
                end
                ST_ADDR: begin
                    if (rise_c) begin
                        sh_d     = rx_byte_c;
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_q == BW'(7)) begin
                            if (rx_byte_c[7:1] == I2C_ADDR) begin
                                rw_d    = rx_byte_c[0];
                                first_d = ~rx_byte_c[0];
                                busy_d  = 1'b1;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // First update pulls the ACK low, the second ends it
                    if (fall_d_q) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                        end else if (rw_q) begin
                            sh_d     = regs_q[ptr_q];
                            sda_t_d  = regs_q[ptr_q][7];
                            ptr_d    = ptr_q + AW'(1);
                            bitcnt_d = '0;
                            state_d  = ST_RD_DATA;
                        end else begin
                            sda_t_d  = 1'b1;
                            bitcnt_d = '0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (rise_c) begin
                        sh_d     = rx_byte_c;
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_q == BW'(7)) begin
                            state_d = ST_WR_ACK;
                            if (first_q) begin
                                ptr_d   = AW'(rx_byte_c);
                                first_d = 1'b0;
                            end else begin
                                i2c_we_c   = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = rx_byte_c;
                                ptr_d      = ptr_q + AW'(1);
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (fall_d_q) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                        end else begin
                            sda_t_d  = 1'b1;
                            bitcnt_d = '0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (rise_c) begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end else if (fall_d_q) begin
                        if (bitcnt_q >= BW'(8)) begin
                            sda_t_d = 1'b1;
                            state_d = ST_RD_ACK;
                        end else begin
                            sda_t_d = sh_q[3'(BW'(7) - bitcnt_q)];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (rise_c) begin
                        if (!sda_f) begin
                            sh_d     = regs_q[ptr_q];
                            ptr_d    = ptr_q + AW'(1);
                            bitcnt_d = '0;
                            state_d  = ST_RD_DATA;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    sda_t_d = 1'b1;
                end
                default: begin
                    sda_t_d = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Local read returns the contents as they will be after this cycle's writes
    always_comb begin
        loc_rdata_d = regs_q[loc_addr];
        if (loc_wr_en) begin
            loc_rdata_d = loc_wdata;
        end
        if (i2c_we_c && (ptr_q == loc_addr)) begin
            loc_rdata_d = rx_byte_c;
        end
    end

    // Register file; the I2C write is last so it wins an index collision
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            if (loc_wr_en) begin
                regs_q[loc_addr] <= loc_wdata;
            end
            if (i2c_we_c) begin
                regs_q[ptr_q] <= rx_byte_c;
            end
        end
    end

endmodule

// File: tb/tb_iic_target_regs.sv
// Directed bench for iic_target_regs: bit-banged I2C initiator with an open-drain SDA model.
module tb_iic_target_regs;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_o;
    logic       sda_t;
    logic       busy;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       loc_wr_en;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Write log and line-activity counters, written only by the monitor
    logic [11:0] wlog [256];
    int          wcnt      = 0;
    int          low_cnt   = 0;
    int          busy_cnt  = 0;
    int          rd_idx    = 0;

    assign sda_bus = sda_m & (sda_t | sda_o);

    iic_target_regs #(
        .I2C_ADDR  (7'h50),
        .NUM_REGS  (16),
        .FILTER_LEN(3)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_o    (sda_o),
        .sda_t    (sda_t),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .loc_wr_en(loc_wr_en),
        .loc_addr (loc_addr),
        .loc_wdata(loc_wdata),
        .loc_rdata(loc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) begin
            wlog[wcnt[7:0]] = {wr_addr, wr_data};
            wcnt = wcnt + 1;
        end
        if (!sda_t) low_cnt = low_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;
        cyc(25);
        scl = 1'b1;
        cyc(25);
        s = sda_bus;
        cyc(25);
        scl = 1'b0;
        cyc(25);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        cyc(25);
        scl = 1'b1;
        cyc(25);
        sda_m = 1'b0;
        cyc(25);
        scl = 1'b0;
        cyc(25);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        cyc(25);
        scl = 1'b1;
        cyc(25);
        sda_m = 1'b1;
        cyc(25);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    task automatic loc_rd(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a;
        cyc(1);
        d = loc_rdata;
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] a, input logic [7:0] d);
        if (rd_idx >= wcnt) begin
            chk(tag, 32'(wcnt - rd_idx), 32'd1);
        end else begin
            chk(tag, 32'(wlog[rd_idx[7:0]]), 32'({a, d}));
            rd_idx++;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         low0;
        int         busy0;
        int         w0;

        reset     = 1'b1;
        scl       = 1'b1;
        sda_m     = 1'b1;
        loc_wr_en = 1'b0;
        loc_addr  = 4'd0;
        loc_wdata = 8'h00;
        cyc(5);
        chk("rst_sda_t", 32'(sda_t), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        reset = 1'b0;
        cyc(20);

        // Write: pointer 3, data 0x11, 0x22
        i2c_start();
        send_byte(8'hA0, ack); chk("wr_ack_addr", 32'(ack), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        send_byte(8'h03, ack); chk("wr_ack_ptr", 32'(ack), 32'd0);
        send_byte(8'h11, ack); chk("wr_ack_d0", 32'(ack), 32'd0);
        send_byte(8'h22, ack); chk("wr_ack_d1", 32'(ack), 32'd0);
        i2c_stop();
        chk("wr_busy_end", 32'(busy), 32'd0);
        chk("wr_count", 32'(wcnt - rd_idx), 32'd2);
        chk_wr("wr_ev0", 4'd3, 8'h11);
        chk_wr("wr_ev1", 4'd4, 8'h22);
        loc_rd(4'd4, d); chk("wr_loc4", 32'(d), 32'h22);
        loc_rd(4'd3, d); chk("wr_loc3", 32'(d), 32'h11);
        cyc(20);

        // Random read with repeated START
        w0 = wcnt;
        i2c_start();
        send_byte(8'hA0, ack); chk("rd_ack_addr", 32'(ack), 32'd0);
        send_byte(8'h03, ack); chk("rd_ack_ptr", 32'(ack), 32'd0);
        i2c_start();
        send_byte(8'hA1, ack); chk("rd_ack_raddr", 32'(ack), 32'd0);
        recv_byte(1'b0, d); chk("rd_byte0", 32'(d), 32'h11);
        recv_byte(1'b1, d); chk("rd_byte1", 32'(d), 32'h22);
        chk("rd_sda_released", 32'(sda_t), 32'd1);
        chk("rd_busy_nack", 32'(busy), 32'd0);
        i2c_stop();
        chk("rd_no_wr", 32'(wcnt - w0), 32'd0);
        cyc(20);

        // Pointer wrap
        i2c_start();
        send_byte(8'hA0, ack); chk("wrap_ack_addr", 32'(ack), 32'd0);
        send_byte(8'h0F, ack);
        send_byte(8'hAA, ack); chk("wrap_ack_d0", 32'(ack), 32'd0);
        send_byte(8'hBB, ack); chk("wrap_ack_d1", 32'(ack), 32'd0);
        i2c_stop();
        chk_wr("wrap_ev0", 4'd15, 8'hAA);
        chk_wr("wrap_ev1", 4'd0, 8'hBB);
        loc_rd(4'd15, d); chk("wrap_loc15", 32'(d), 32'hAA);
        loc_rd(4'd0, d);  chk("wrap_loc0", 32'(d), 32'hBB);
        cyc(20);

        // Address mismatch
        low0  = low_cnt;
        busy0 = busy_cnt;
        w0    = wcnt;
        i2c_start();
        send_byte(8'hA2, ack); chk("mis_nack", 32'(ack), 32'd1);
        send_byte(8'h03, ack);
        send_byte(8'h55, ack);
        i2c_stop();
        chk("mis_sda_low", 32'(low_cnt - low0), 32'd0);
        chk("mis_busy", 32'(busy_cnt - busy0), 32'd0);
        chk("mis_wr", 32'(wcnt - w0), 32'd0);
        cyc(20);

        // Glitch: 2-cycle SDA low while SCL high is not a START
        low0  = low_cnt;
        sda_m = 1'b0;
        cyc(2);
        sda_m = 1'b1;
        cyc(20);
        scl = 1'b0;
        cyc(25);
        send_byte(8'hA0, ack); chk("glitch_nack", 32'(ack), 32'd1);
        chk("glitch_sda_low", 32'(low_cnt - low0), 32'd0);
        i2c_stop();
        cyc(20);

        // 5-cycle SDA low before SCL falls is a START
        sda_m = 1'b0;
        cyc(5);
        scl = 1'b0;
        cyc(25);
        send_byte(8'hA0, ack); chk("start5_ack", 32'(ack), 32'd0);
        chk("start5_busy", 32'(busy), 32'd1);
        i2c_stop();
        chk("start5_busy_end", 32'(busy), 32'd0);
        cyc(20);

        // Local write with forwarded read-back
        loc_addr  = 4'd9;
        loc_wdata = 8'h99;
        loc_wr_en = 1'b1;
        cyc(1);
        loc_wr_en = 1'b0;
        chk("loc_fwd", 32'(loc_rdata), 32'h99);
        loc_rd(4'd9, d); chk("loc_hold", 32'(d), 32'h99);

        // Reset while the address ACK is driven low
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic s;
            d = 8'hA0;
            bit_xfer(d[i], s);
        end
        sda_m = 1'b1;
        cyc(25);
        chk("rst_ack_driven", 32'(sda_t), 32'd0);
        reset = 1'b1;
        cyc(1);
        chk("rst_ack_release", 32'(sda_t), 32'd1);
        cyc(4);
        scl   = 1'b1;
        sda_m = 1'b1;
        cyc(10);
        reset = 1'b0;
        cyc(20);
        chk("rst_busy_after", 32'(busy), 32'd0);
        loc_rd(4'd9, d); chk("rst_reg9", 32'(d), 32'h00);
        loc_rd(4'd3, d); chk("rst_reg3", 32'(d), 32'h00);
        i2c_start();
        send_byte(8'hA0, ack); chk("post_ack_addr", 32'(ack), 32'd0);
        send_byte(8'h07, ack); chk("post_ack_ptr", 32'(ack), 32'd0);
        send_byte(8'h77, ack); chk("post_ack_d0", 32'(ack), 32'd0);
        i2c_stop();
        chk_wr("post_ev0", 4'd7, 8'h77);
        loc_rd(4'd7, d); chk("post_loc7", 32'(d), 32'h77);
        cyc(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iic_target_regs.md
Name: iic_target_regs

Overview:
I2C target (responder) with a byte-wide register file, the far end of the iic_main initiator bus. It connects to the same open-drain _i/_o/_t triplet style through external IOBUFs and answers one 7-bit address. It supports write with register pointer, sequential read with auto-increment, and repeated START. A local port lets fabric logic read and preload registers. Clock stretching is not supported.

Parameters:
I2C_ADDR, 7'h50, 7-bit target address matched against the address byte.
NUM_REGS, 16, register count; power of two, 2..256; AW = log2(NUM_REGS).
FILTER_LEN, 3, consecutive equal synced samples required before a filtered line changes.

Ports:
clock  input  1  single system clock.
reset  input  1  synchronous, active-high.
scl_i  input  1  SCL from IOBUF (SCL is input only).
sda_i  input  1  SDA from IOBUF.
sda_o  output  1  SDA drive value, constant 0.
sda_t  output  1  SDA tristate: 0 = pull low, 1 = release.
busy  output  1  high from matched START until STOP or until the target returns to idle.
wr_valid  output  1  one-cycle pulse per I2C data byte written to the register file.
wr_addr  output  AW  register index of the wr_valid byte.
wr_data  output  8  data of the wr_valid byte.
loc_wr_en  input  1  local register write enable.
loc_addr  input  AW  local register index (read and write).
loc_wdata  input  8  local write data.
loc_rdata  output  8  reg[loc_addr], registered, 1-cycle latency.

Behaviour:
- Reset state: sda_t=1, busy=0, wr_valid=0, wr_addr=0, wr_data=0, loc_rdata=0, all regs=0, ptr=0, state IDLE. Filtered SCL/SDA reset to 1.
- Input path: each of scl_i and sda_i passes through a 2-flop synchronizer, then a counter filter. A filtered line takes the synced value after FILTER_LEN consecutive equal samples. Pulses shorter than FILTER_LEN cycles are ignored.
- Bus events, on filtered lines only:
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
  - Bit sample: SCL rising edge.
  - Drive update: one cycle after an SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START from any state -> ADDR, clear bit counter, release SDA. This covers repeated START.
- STOP from any state -> IDLE, sda_t=1, busy=0.
- ADDR: shift 8 bits MSB first.
  - On match with R/W=0 -> ADDR_ACK (write); with R/W=1 -> ADDR_ACK (read). busy=1.
  - On mismatch -> IGNORE, SDA released until the next START or STOP.
- ADDR_ACK: pull SDA low from the falling edge after bit 8 to the falling edge after the 9th SCL pulse.
  - Write: -> WR_DATA.
  - Read: load shift register with reg[ptr], increment ptr, -> RD_DATA.
- WR_DATA: receive 8 bits, then -> WR_ACK (ACK driven low). At the start of WR_ACK:
  - First byte after the address: ptr = byte[AW-1:0]. No wr_valid.
  - Later bytes: reg[ptr] = byte, pulse wr_valid with wr_addr=ptr and wr_data=byte, then ptr = ptr+1 modulo NUM_REGS (wrap).
  - After the ACK clock -> WR_DATA.
- RD_DATA: drive shift-register bits MSB first; a 1 bit releases SDA. After 8 bits, release SDA -> RD_ACK.
- RD_ACK: sample SDA at the 9th SCL rise.
  - Low (ACK): load reg[ptr], ptr+1 with wrap, -> RD_DATA.
  - High (NACK): -> IGNORE with busy=0; wait for START or STOP.
- ptr persists across transactions, which allows a current-address read.
- Local port:
  - loc_wr_en writes reg[loc_addr] in the same cycle.
  - If an I2C write hits the same index in the same cycle, the I2C write wins.
  - loc_rdata returns post-write contents one cycle later.
- Reset asserted mid-transaction: immediate return to reset state. SDA is released on the next cycle, so the bus is never held low.

Test Plan:
- Write: SCL period 100 cycles; START, 0xA0, 0x03, 0x11, 0x22, STOP -> ACK on all 4 bytes; wr_valid pulses (3,0x11) then (4,0x22); loc_rdata at loc_addr=4 reads 0x22.
- Random read: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> returns 0x11, 0x22; SDA released after the NACK; busy falls.
- Wrap-around: pointer 0x0F, write 0xAA, 0xBB -> reg[15]=0xAA, reg[0]=0xBB; wr_addr sequence 15, 0.
- Address mismatch: START, 0xA2, bytes -> sda_t stays 1 throughout, no wr_valid, busy=0.
- Glitch: 2-cycle SDA low pulse while SCL high -> no START detected; a 5-cycle pulse -> START detected.
- Reset while driving the ACK low -> sda_t=1 within 1 cycle; regs=0; the next normal transaction succeeds.
